// File: rtl/tlb_lookup_if.sv
// rtl/tlb_lookup_if.sv - lookup, entry-write and INVTLB signal bundle for tlb_lookup
interface tlb_lookup_if #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
);
  logic             req_valid;
  logic             req_ready;
  logic [18:0]      req_vppn;
  logic             req_odd;
  logic [9:0]       req_asid;

  logic             resp_valid;
  logic             resp_hit;
  logic [IDX_W-1:0] resp_idx;
  logic [19:0]      resp_pfn;
  logic             resp_ne;
  logic             resp_d;
  logic [1:0]       resp_mat;
  logic [1:0]       resp_plv;

  logic             we;
  logic [IDX_W-1:0] w_idx;
  logic             w_e;
  logic             w_g;
  logic [5:0]       w_ps;
  logic [18:0]      w_vppn;
  logic [9:0]       w_asid;
  logic [25:0]      w_lo0;
  logic [25:0]      w_lo1;

  logic             inv_valid;
  logic [4:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vppn;
  logic             inv_busy;
  logic             inv_done;

  modport master (
    output req_valid, req_vppn, req_odd, req_asid,
    input  req_ready,
    input  resp_valid, resp_hit, resp_idx, resp_pfn, resp_ne, resp_d, resp_mat, resp_plv,
    output we, w_idx, w_e, w_g, w_ps, w_vppn, w_asid, w_lo0, w_lo1,
    output inv_valid, inv_op, inv_asid, inv_vppn,
    input  inv_busy, inv_done
  );

  modport slave (
    input  req_valid, req_vppn, req_odd, req_asid,
    output req_ready,
    output resp_valid, resp_hit, resp_idx, resp_pfn, resp_ne, resp_d, resp_mat, resp_plv,
    input  we, w_idx, w_e, w_g, w_ps, w_vppn, w_asid, w_lo0, w_lo1,
    input  inv_valid, inv_op, inv_asid, inv_vppn,
    output inv_busy, inv_done
  );
endinterface

// File: rtl/tlb_lookup.sv
// rtl/tlb_lookup.sv - fully-associative TLB: 1-cycle lookup, entry write, INVTLB walk
// Optional hit/miss counters enabled by TLB_PERF_EN.
module tlb_lookup #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic        clk,
  input  logic        resetn,
  tlb_lookup_if.slave bus
`ifdef TLB_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [4:0]       r_inv_op;
  logic [9:0]       r_inv_asid;
  logic [18:0]      r_inv_vppn;
  logic             r_inv_busy;
  logic             r_inv_done;

  logic             r_e    [TLBNUM];
  logic             r_g    [TLBNUM];
  logic [5:0]       r_ps   [TLBNUM];
  logic [18:0]      r_vppn [TLBNUM];
  logic [9:0]       r_asid [TLBNUM];
  logic [25:0]      r_lo0  [TLBNUM];
  logic [25:0]      r_lo1  [TLBNUM];

  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [IDX_W-1:0] r_resp_idx;
  logic [19:0]      r_resp_pfn;
  logic             r_resp_ne;
  logic             r_resp_d;
  logic [1:0]       r_resp_mat;
  logic [1:0]       r_resp_plv;

  logic [TLBNUM-1:0] w_match;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic [25:0]       w_lo;
  logic              w_accept;
  logic              w_inv_asid_m;
  logic              w_inv_va_m;
  logic              w_inv_cond;
  logic              w_walk_clr;

  assign bus.req_ready = (r_state == IDLE) & ~bus.inv_valid;
  assign w_accept      = bus.req_valid & bus.req_ready;

  // A 2MB entry (ps=21) ignores the low 9 VPPN bits.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_match[i] = r_e[i] & (r_g[i] | (r_asid[i] == bus.req_asid)) &
                   ((r_ps[i] == 6'd21) ? (r_vppn[i][18:9] == bus.req_vppn[18:9])
                                       : (r_vppn[i] == bus.req_vppn));
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_lo      = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
        w_lo      = ((r_ps[i] == 6'd21) ? bus.req_vppn[8] : bus.req_odd) ? r_lo1[i] : r_lo0[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= '0;
      r_resp_pfn   <= '0;
      r_resp_ne    <= 1'b1;
      r_resp_d     <= 1'b0;
      r_resp_mat   <= '0;
      r_resp_plv   <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_resp_hit <= w_hit;
        r_resp_idx <= w_hit_idx;
        r_resp_pfn <= w_lo[25:6];
        r_resp_ne  <= ~(w_hit & w_lo[0]);
        r_resp_d   <= w_lo[1];
        r_resp_mat <= w_lo[3:2];
        r_resp_plv <= w_lo[5:4];
      end
    end
  end

  always_comb begin
    w_inv_asid_m = (r_asid[r_ptr] == r_inv_asid);
    w_inv_va_m   = (r_ps[r_ptr] == 6'd21) ? (r_vppn[r_ptr][18:9] == r_inv_vppn[18:9])
                                          : (r_vppn[r_ptr] == r_inv_vppn);
    w_inv_cond   = 1'b0;
    case (r_inv_op)
      5'd0, 5'd1: w_inv_cond = 1'b1;
      5'd2:       w_inv_cond = r_g[r_ptr];
      5'd3:       w_inv_cond = ~r_g[r_ptr];
      5'd4:       w_inv_cond = ~r_g[r_ptr] & w_inv_asid_m;
      5'd5:       w_inv_cond = ~r_g[r_ptr] & w_inv_asid_m & w_inv_va_m;
      5'd6:       w_inv_cond = (r_g[r_ptr] | w_inv_asid_m) & w_inv_va_m;
      default:    w_inv_cond = 1'b0;
    endcase
  end

  assign w_walk_clr = (r_state == WALK) & w_inv_cond;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_inv_busy <= 1'b0;
      r_inv_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.inv_valid) begin
            r_state    <= WALK;
            r_ptr      <= '0;
            r_inv_op   <= bus.inv_op;
            r_inv_asid <= bus.inv_asid;
            r_inv_vppn <= bus.inv_vppn;
            r_inv_busy <= 1'b1;
          end
        end
        WALK: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == IDX_W'(TLBNUM - 1)) begin
            r_state    <= DONE;
            r_inv_done <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_inv_done <= 1'b0;
          r_inv_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A write landing on the entry the walk is clearing this cycle keeps the written value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) begin
        r_e[i]    <= 1'b0;
        r_g[i]    <= 1'b0;
        r_ps[i]   <= '0;
        r_vppn[i] <= '0;
        r_asid[i] <= '0;
        r_lo0[i]  <= '0;
        r_lo1[i]  <= '0;
      end
    end else begin
      if (w_walk_clr) begin
        r_e[r_ptr] <= 1'b0;
      end
      if (bus.we) begin
        r_e[bus.w_idx]    <= bus.w_e;
        r_g[bus.w_idx]    <= bus.w_g;
        r_ps[bus.w_idx]   <= bus.w_ps;
        r_vppn[bus.w_idx] <= bus.w_vppn;
        r_asid[bus.w_idx] <= bus.w_asid;
        r_lo0[bus.w_idx]  <= bus.w_lo0;
        r_lo1[bus.w_idx]  <= bus.w_lo1;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_idx   = r_resp_idx;
  assign bus.resp_pfn   = r_resp_pfn;
  assign bus.resp_ne    = r_resp_ne;
  assign bus.resp_d     = r_resp_d;
  assign bus.resp_mat   = r_resp_mat;
  assign bus.resp_plv   = r_resp_plv;
  assign bus.inv_busy   = r_inv_busy;
  assign bus.inv_done   = r_inv_done;

`ifdef TLB_PERF_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else begin
      if (r_resp_valid & r_resp_hit & ~r_resp_ne) begin
        r_perf_hit <= r_perf_hit + 32'd1;
      end
      if (r_resp_valid & r_resp_ne) begin
        r_perf_miss <= r_perf_miss + 32'd1;
      end
    end
  end

  assign perf_hit  = r_perf_hit;
  assign perf_miss = r_perf_miss;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// tb/tb_tlb_lookup.sv - randomized bench for tlb_lookup against a behavioural TLB model
module tb_tlb_lookup;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  tlb_lookup_if #(.TLBNUM(N)) bus();

`ifdef TLB_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  tlb_lookup #(.TLBNUM(N)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
`ifdef TLB_PERF_EN
    ,
    .perf_hit(perf_hit),
    .perf_miss(perf_miss)
`endif
  );

  // Behavioural model: entry table, walk modelled as an instant clear plus a busy countdown.
  bit          m_e    [N];
  bit          m_g    [N];
  logic [5:0]  m_ps   [N];
  logic [18:0] m_vppn [N];
  logic [9:0]  m_asid [N];
  logic [25:0] m_lo0  [N];
  logic [25:0] m_lo1  [N];
  int          m_busy = 0;
  bit          x_valid = 0;
  bit          x_hit   = 0;
  bit          x_ne    = 1;
  int          x_idx   = 0;
  logic [25:0] x_lo    = '0;
  int unsigned m_ph = 0;
  int unsigned m_pm = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit va_match(int i, logic [18:0] va);
    if (m_ps[i] == 6'd21) return m_vppn[i][18:9] == va[18:9];
    return m_vppn[i] == va;
  endfunction

  function automatic bit inv_hit(int i, int op, logic [9:0] a, logic [18:0] va);
    bit am = (m_asid[i] == a);
    bit vm = va_match(i, va);
    case (op)
      0, 1: return 1'b1;
      2:    return m_g[i];
      3:    return !m_g[i];
      4:    return !m_g[i] && am;
      5:    return !m_g[i] && am && vm;
      6:    return (m_g[i] || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) m_e[i] = 1'b0;
      m_busy = 0; x_valid = 0; x_hit = 0; x_ne = 1; x_idx = 0; x_lo = '0;
      m_ph = 0; m_pm = 0;
    end else begin
      if (x_valid && x_hit && !x_ne) m_ph++;
      if (x_valid && x_ne) m_pm++;
      x_valid = bus.req_valid && (m_busy == 0) && !bus.inv_valid;
      if (x_valid) begin
        x_hit = 0; x_idx = 0; x_lo = '0;
        for (int i = 0; i < N; i++) begin
          if (!x_hit && m_e[i] && (m_g[i] || m_asid[i] == bus.req_asid) && va_match(i, bus.req_vppn)) begin
            x_hit = 1;
            x_idx = i;
            x_lo  = ((m_ps[i] == 6'd21) ? bus.req_vppn[8] : bus.req_odd) ? m_lo1[i] : m_lo0[i];
          end
        end
        x_ne = !(x_hit && x_lo[0]);
      end
      if (m_busy > 0) m_busy--;
      else if (bus.inv_valid) begin
        for (int i = 0; i < N; i++)
          if (inv_hit(i, int'(bus.inv_op), bus.inv_asid, bus.inv_vppn)) m_e[i] = 1'b0;
        m_busy = N + 1;
      end
      if (bus.we) begin
        m_e[bus.w_idx]    = bus.w_e;
        m_g[bus.w_idx]    = bus.w_g;
        m_ps[bus.w_idx]   = bus.w_ps;
        m_vppn[bus.w_idx] = bus.w_vppn;
        m_asid[bus.w_idx] = bus.w_asid;
        m_lo0[bus.w_idx]  = bus.w_lo0;
        m_lo1[bus.w_idx]  = bus.w_lo1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 32'(bus.req_ready), 32'(m_busy == 0 && !bus.inv_valid));
    chk("inv_busy", 32'(bus.inv_busy), 32'(m_busy > 0));
    chk("inv_done", 32'(bus.inv_done), 32'(m_busy == 1));
    chk("resp_valid", 32'(bus.resp_valid), 32'(x_valid));
    chk("resp_hit", 32'(bus.resp_hit), 32'(x_hit));
    chk("resp_idx", 32'(bus.resp_idx), 32'(x_idx));
    chk("resp_pfn", 32'(bus.resp_pfn), x_hit ? 32'(x_lo[25:6]) : 32'd0);
    chk("resp_ne", 32'(bus.resp_ne), 32'(x_ne));
    if (x_hit) begin
      chk("resp_d", 32'(bus.resp_d), 32'(x_lo[1]));
      chk("resp_mat", 32'(bus.resp_mat), 32'(x_lo[3:2]));
      chk("resp_plv", 32'(bus.resp_plv), 32'(x_lo[5:4]));
    end
`ifdef TLB_PERF_EN
    chk("perf_hit", perf_hit, m_ph);
    chk("perf_miss", perf_miss, m_pm);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid = 1'b0;
    bus.we        = 1'b0;
    bus.inv_valid = 1'b0;
  endtask

  task automatic set_w(int idx, bit e, bit g, int ps, logic [18:0] vppn, logic [9:0] asid,
                       logic [25:0] lo0, logic [25:0] lo1);
    bus.w_idx  = IW'(idx);
    bus.w_e    = e;
    bus.w_g    = g;
    bus.w_ps   = 6'(ps);
    bus.w_vppn = vppn;
    bus.w_asid = asid;
    bus.w_lo0  = lo0;
    bus.w_lo1  = lo1;
  endtask

  task automatic wr(int idx, bit e, bit g, int ps, logic [18:0] vppn, logic [9:0] asid,
                    logic [25:0] lo0, logic [25:0] lo1);
    set_w(idx, e, g, ps, vppn, asid, lo0, lo1);
    bus.we = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  task automatic look(logic [18:0] vppn, bit odd, logic [9:0] asid);
    bus.req_valid = 1'b1;
    bus.req_vppn  = vppn;
    bus.req_odd   = odd;
    bus.req_asid  = asid;
    step();
    bus.req_valid = 1'b0;
  endtask

  function automatic logic [18:0] pick_va();
    logic [18:0] pool [6];
    pool[0] = 19'h00010; pool[1] = 19'h00011; pool[2] = 19'h40000;
    pool[3] = 19'h40123; pool[4] = 19'h12345; pool[5] = 19'h401FF;
    return pool[$urandom_range(0, 5)];
  endfunction

  int busy_cycles;
  int done_cnt;
  int rdy_bad;
  int r;

  initial begin
    idle_in();
    bus.req_vppn = '0; bus.req_odd = 1'b0; bus.req_asid = '0;
    set_w(0, 0, 0, 12, '0, '0, '0, '0);
    bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
    #1 resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_ne", 32'(bus.resp_ne), 32'd1);
    chk("rst_busy", 32'(bus.inv_busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    look(19'h00001, 1'b0, 10'd0);
    chk("tp_empty_valid", 32'(bus.resp_valid), 32'd1);
    chk("tp_empty_hit", 32'(bus.resp_hit), 32'd0);
    chk("tp_empty_ne", 32'(bus.resp_ne), 32'd1);
    chk("tp_empty_pfn", 32'(bus.resp_pfn), 32'd0);

    wr(3, 1, 0, 12, 19'h12345, 10'd5, 26'h0, {20'hABCDE, 2'd3, 2'd1, 1'b1, 1'b1});
    look(19'h12345, 1'b1, 10'd5);
    chk("tp4k_hit", 32'(bus.resp_hit), 32'd1);
    chk("tp4k_idx", 32'(bus.resp_idx), 32'd3);
    chk("tp4k_pfn", 32'(bus.resp_pfn), 32'hABCDE);
    chk("tp4k_ne", 32'(bus.resp_ne), 32'd0);
    chk("tp4k_d", 32'(bus.resp_d), 32'd1);
    chk("tp4k_mat", 32'(bus.resp_mat), 32'd1);
    chk("tp4k_plv", 32'(bus.resp_plv), 32'd3);
    look(19'h12345, 1'b1, 10'd6);
    chk("tp4k_asid_ne", 32'(bus.resp_ne), 32'd1);

    wr(0, 1, 1, 21, 19'h40000, 10'd0, {20'h00200, 6'b000001}, 26'h0);
    look(19'h400FF, 1'b0, 10'd9);
    chk("tp2m_hit", 32'(bus.resp_hit), 32'd1);
    chk("tp2m_idx", 32'(bus.resp_idx), 32'd0);
    chk("tp2m_pfn", 32'(bus.resp_pfn), 32'h00200);
    look(19'h40100, 1'b0, 10'd9);
    chk("tp2m_odd_hit", 32'(bus.resp_hit), 32'd1);
    chk("tp2m_odd_ne", 32'(bus.resp_ne), 32'd1);

    wr(2, 1, 1, 12, 19'h02222, 10'd0, {20'h11111, 6'b000001}, 26'h0);
    set_w(2, 1, 1, 12, 19'h02222, 10'd0, {20'h22222, 6'b000001}, 26'h0);
    bus.we = 1'b1;
    look(19'h02222, 1'b0, 10'd0);
    bus.we = 1'b0;
    chk("wr_same_old", 32'(bus.resp_pfn), 32'h11111);
    look(19'h02222, 1'b0, 10'd0);
    chk("wr_next_new", 32'(bus.resp_pfn), 32'h22222);

    for (int i = 0; i < N; i++)
      wr(i, 1, i[0], 12, 19'h00100 + 19'(i), 10'd7, {20'(i + 1), 6'b000001}, 26'h0);
    bus.inv_valid = 1'b1; bus.inv_op = 5'd2;
    step();
    bus.inv_valid = 1'b0;
    busy_cycles = 0; done_cnt = 0; rdy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.inv_busy) busy_cycles++;
      if (bus.inv_done) done_cnt++;
      if (bus.inv_busy && bus.req_ready) rdy_bad++;
      step();
    end
    chk("walk_busy_cycles", busy_cycles, 17);
    chk("walk_done_pulses", done_cnt, 1);
    chk("walk_ready_low", rdy_bad, 0);
    look(19'h00100, 1'b0, 10'd7);
    chk("op2_g0_hit", 32'(bus.resp_hit), 32'd1);
    chk("op2_g0_pfn", 32'(bus.resp_pfn), 32'd1);
    look(19'h00101, 1'b0, 10'd7);
    chk("op2_g1_miss", 32'(bus.resp_hit), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      idle_in();
      r = int'($urandom_range(0, 99));
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_vppn  = pick_va() ^ (($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 511)) : 19'h0);
      bus.req_odd   = 1'($urandom_range(0, 1));
      bus.req_asid  = 10'($urandom_range(0, 3));
      if (m_busy == 0) begin
        if (r < 4) begin
          bus.inv_valid = 1'b1;
          bus.inv_op    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
          bus.inv_asid  = 10'($urandom_range(0, 3));
          bus.inv_vppn  = pick_va();
        end else if (r < 40) begin
          set_w(int'($urandom_range(0, N - 1)), ($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 21 : 12,
                pick_va(), 10'($urandom_range(0, 3)), 26'($urandom), 26'($urandom));
          bus.we = 1'b1;
        end
      end else if (r < 10) begin
        bus.inv_valid = 1'b1;
        bus.inv_op    = 5'd0;
      end
      step();
    end
    idle_in();

    for (int k = 0; k < 40 && m_busy != 0; k++) step();
    chk("pre_reset_idle", m_busy, 0);
    for (int i = 0; i < N; i++)
      wr(i, 1, 1, 12, 19'h00100 + 19'(i), 10'd7, {20'(i + 1), 6'b000001}, 26'h0);
    bus.inv_valid = 1'b1; bus.inv_op = 5'd31;
    step();
    bus.inv_valid = 1'b0;
    repeat (5) step();
    resetn = 1'b0;
    #1;
    chk("midwalk_busy", 32'(bus.inv_busy), 32'd0);
    chk("midwalk_done", 32'(bus.inv_done), 32'd0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) look(19'h00100 + 19'(i % N), 1'b0, 10'd7);
    look(19'h00100, 1'b0, 10'd7);
    chk("post_reset_miss", 32'(bus.resp_hit), 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlb_lookup.md
Name: tlb_lookup

Overview:
- Fully-associative LoongArch-style TLB that answers the translation requests issued by the address-translation stage.
- Accepts a virtual page request and returns pfn, tlb_ne and attribute bits one cycle later.
- Also services TLB writes (TLBWR/TLBFILL) and a multi-cycle INVTLB walk.
- Sits between the address-translation logic and the CSR/TLB-instruction unit.

Parameters:
TLBNUM, 16, number of entries (power of two, 4..64)
IDX_W, $clog2(TLBNUM), index width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  lookup request
req_ready  output  1  lookup accepted this cycle
req_vppn  input  19  virt_addr[31:13]
req_odd  input  1  virt_addr[12]
req_asid  input  10  current ASID
resp_valid  output  1  lookup result valid
resp_hit  output  1  matching entry found
resp_idx  output  IDX_W  matching entry index
resp_pfn  output  20  physical frame number
resp_ne  output  1  not-exist: high when no hit or hit with V=0
resp_d  output  1  dirty bit
resp_mat  output  2  memory access type
resp_plv  output  2  entry privilege
we  input  1  write entry
w_idx  input  IDX_W  write index
w_e, w_g  input  1 each  exist, global
w_ps  input  6  page size, 12 or 21
w_vppn  input  19  entry VPPN
w_asid  input  10  entry ASID
w_lo0, w_lo1  input  26 each  {pfn[19:0],plv[1:0],mat[1:0],d,v} for even/odd page
inv_valid  input  1  start INVTLB
inv_op  input  5  op 0..6
inv_asid  input  10  ASID operand
inv_vppn  input  19  VA operand
inv_busy  output  1  walk in progress
inv_done  output  1  one-cycle pulse at walk end

Behaviour:
- Reset: all entries have E=0. resp_valid=0, resp_hit=0, resp_idx=0, resp_pfn=0, resp_ne=1, resp_d=0, resp_mat=0, resp_plv=0, inv_busy=0, inv_done=0. State is IDLE.
- Match rule for entry i:
  - E=1, and
  - (G=1 or ASID==req_asid), and
  - VPPN compares bits [18:0] when ps=12, bits [18:9] when ps=21.
- Odd/even page select:
  - ps=12 selects lo1 if req_odd, else lo0.
  - ps=21 selects lo1 if req_vppn[8], else lo0.
- Multiple hits: the lowest index wins. Software must prevent this; the rule makes the result deterministic.
- Latency: a request accepted at cycle N (req_valid & req_ready) is registered and produces resp_valid=1 at N+1 with all result fields.
  - resp_valid=0 in cycles without an accepted request.
  - Result fields hold their last value when resp_valid=0.
- Full pipelining: one request per cycle, back-to-back.
- resp_ne = ~hit | ~v_selected. On a miss, resp_pfn=0 and resp_idx=0.
- Write:
  - Takes effect at the clock edge where we=1.
  - A lookup in the same cycle sees the old contents.
  - A lookup in the next cycle sees the new contents.
- req_ready = (state==IDLE) & ~inv_valid. A write may coincide with a lookup.
- FSM states: IDLE, WALK, DONE.
  - IDLE -> WALK on inv_valid. inv_op/asid/vppn are latched and the walk pointer is set to 0. inv_valid is ignored while inv_busy=1.
  - WALK: one entry per cycle; clears E when the op condition holds; pointer increments.
    - op0/1: all entries.
    - op2: G=1.
    - op3: G=0.
    - op4: G=0 & ASID match.
    - op5: G=0 & ASID match & VA match.
    - op6: (G=1 | ASID match) & VA match.
    - op 7..31: no entry cleared; the walk still runs.
  - WALK -> DONE after pointer TLBNUM-1 is processed. DONE pulses inv_done=1 for one cycle, then returns to IDLE.
  - inv_busy=1 in WALK and DONE.
- Write during WALK: applied. The walk may then clear that entry if it has not yet passed the index; this is accepted.
- Reset mid-walk: returns to IDLE, all E=0, no inv_done.

Optional Feature:
- TLB_PERF_EN defined: adds outputs perf_hit and perf_miss, 32 bits each.
  - Counters increment on each resp_valid with hit (v=1) or resp_ne=1 respectively.
  - Counters wrap at 2^32 and reset to 0.
- TLB_PERF_EN undefined: ports and counters are absent; there is no other change.

Test Plan:
- Reset, lookup vppn=0x00001, odd=0 -> next cycle resp_valid=1, resp_hit=0, resp_ne=1, resp_pfn=0.
- Write idx3: E=1, G=0, ps=12, vppn=0x12345, asid=5, lo1 pfn=0xABCDE v=1 d=1 mat=1 plv=3.
  - Lookup vppn=0x12345, odd=1, asid=5 -> resp_hit=1, resp_idx=3, resp_pfn=0xABCDE, resp_ne=0, resp_d=1, resp_mat=1, resp_plv=3.
  - Same lookup with asid=6 -> resp_ne=1.
- Write 2MB entry idx0: ps=21, G=1, vppn=0x40000, lo0 pfn=0x00200 v=1.
  - Lookup vppn=0x400FF -> hit idx0, pfn=0x00200.
  - Lookup vppn=0x40100 -> hit with lo1 (v=0) -> resp_ne=1.
- Same-cycle write and lookup to idx2 -> old contents returned; lookup in the next cycle -> new contents.
- Fill all 16 entries, alternating G. inv_op=2 -> inv_busy high for exactly 17 cycles, inv_done one pulse, req_ready=0 throughout; afterwards only G=0 entries hit.
- Assert resetn=0 at walk cycle 5 -> inv_busy=0 immediately, no inv_done; every lookup afterwards misses.
